multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
Multi-cycle MIPS control unit that sequences the shared datapath (single memory, single ALU, IR, PC) over several clock cycles per instruction. It replaces the single-cycle decoder for the multi-cycle core variant. It supports the R-type, addi, addiu, lw, sw, beq and j opcodes. It sits between the instruction register opcode field and the datapath mux/enable controls, and waits on a memory ready handshake.

Parameters:
CNT_W, 32, width of the optional performance counters.

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous, active-high reset
i_instrCode  in  6  opcode field from IR, stable from DECODE until the next FETCH
i_memReady  in  1  memory access completes this cycle
o_pcWrite  out  1  unconditional PC write
o_pcWriteCond  out  1  PC write if ALU zero
o_iorD  out  1  memory address select: 0 = PC, 1 = ALUOut
o_memRead  out  1  memory read request
o_memWrite  out  1  memory write request
o_irWrite  out  1  IR load
o_regDst  out  1  destination register: 1 = rd, 0 = rt
o_memToReg  out  1  writeback source: 1 = MDR, 0 = ALUOut
o_regWrite  out  1  register file write
o_aluSrcA  out  1  ALU A operand: 0 = PC, 1 = rs
o_aluSrcB  out  2  ALU B operand: 00 = rt, 01 = 4, 10 = imm, 11 = imm<<2
o_aluOp  out  2  00 = add, 01 = sub, 10 = funct
o_pcSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
o_extOp  out  1  1 = sign-extend imm, 0 = zero-extend
o_illegal  out  1  unsupported opcode seen in DECODE
o_state  out  4  current state, for debug

Behaviour:
- Moore FSM, 4-bit state register. Outputs decode from state. Exceptions: o_irWrite and o_pcWrite in FETCH are gated by i_memReady, and o_illegal/o_extOp depend on i_instrCode.
- Reset: state = FETCH (0). While i_rst is high, o_irWrite = o_pcWrite = 0; all other outputs take their FETCH values: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=00, everything else 0. o_illegal = 0.
- Any output not listed for a state is 0.
- FETCH(0): memRead=1, aluSrcB=01, aluOp=00, pcSource=00; irWrite = pcWrite = i_memReady. Stays in FETCH while i_memReady=0, otherwise goes to DECODE.
- DECODE(1): aluSrcB=11, aluOp=00 (branch target to ALUOut). Next state by opcode:
  - 100011 or 101011 -> MEMADR
  - 000000 -> EXEC
  - 001000 or 001001 -> IMMEX
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - any other opcode -> FETCH, with o_illegal=1 for this one cycle.
- MEMADR(2): aluSrcA=1, aluSrcB=10, aluOp=00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD(3): memRead=1, iorD=1. Holds until i_memReady, then MEMWB.
- MEMWB(4): regWrite=1, memToReg=1, regDst=0. Next FETCH.
- MEMWR(5): memWrite=1, iorD=1. Holds until i_memReady, then FETCH.
- EXEC(6): aluSrcA=1, aluSrcB=00, aluOp=10. Next RWB.
- RWB(7): regWrite=1, regDst=1, memToReg=0. Next FETCH.
- BRANCH(8): aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=01. Next FETCH.
- JUMP(9): pcWrite=1, pcSource=10. Next FETCH.
- IMMEX(10): aluSrcA=1, aluSrcB=10, aluOp=00. Next IMMWB.
- IMMWB(11): regWrite=1, regDst=0, memToReg=0. Next FETCH.
- Codes 12–15 are unreachable. If entered, next state is FETCH with all outputs 0.
- o_extOp = 1 for 001000, 100011, 101011 and 000100; 0 otherwise (including addiu).
- Cycle counts with i_memReady held at 1: R-type 4, addi/addiu 4, lw 5, sw 4, beq 3, j 3, illegal 2. Each cycle of i_memReady=0 in a wait state adds one cycle.
- An asynchronous reset mid-instruction aborts it: state returns to FETCH immediately and no partial write is issued after reset deasserts.

Optional Feature:
- Macro: MULTICYCLE_CONTROL_PERF_EN.
- Defined: adds outputs o_cycleCount[CNT_W] and o_instrCount[CNT_W], both reset to 0.
  - o_cycleCount increments every cycle i_rst is low.
  - o_instrCount increments on every transition into FETCH from a non-FETCH state, illegal opcodes included.
  - Both counters saturate at all-ones.
- Undefined: the ports and counters are absent; FSM behaviour is identical.

Decomposition:
- Shared package mips_pkg holds:
  - opcode localparams: OP_RTYPE, OP_ADDI, OP_ADDIU, OP_LW, OP_SW, OP_BEQ, OP_J;
  - the state encoding enum (4 bits);
  - aluOp, aluSrcB and pcSource codes.
- No sub-module. The FSM and output decode live in one module; the counters sit inside the ifdef in the same file.

Test Plan:
- Reset held, then released with i_memReady=1 and opcode 000000 -> state sequence 0,1,6,7,0; regWrite=1 and regDst=1 only in state 7.
- lw (100011) with i_memReady low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; iorD=1 throughout state 3; memToReg=1 in state 4.
- beq (000100) -> 0,1,8,0; in state 8 pcWriteCond=1, aluOp=01, pcSource=01; extOp=1.
- j (000010), then addiu (001001) -> 0,1,9,0 followed by 0,1,10,11,0; extOp=0 for addiu.
- Opcode 111111 -> o_illegal=1 for exactly one cycle in state 1, then back to 0. Assert i_rst during state 3 of a lw -> state 0 at once, with no regWrite pulse afterwards.
- With MULTICYCLE_CONTROL_PERF_EN: run the sequence R-type, lw, sw, beq, j with memReady=1 -> o_instrCount=5, o_cycleCount=19.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the multi-cycle core: opcodes, control FSM state
// encoding and the datapath mux/ALU select codes driven by the control unit.
package mips_pkg;

    // Opcode field values (IR[31:26]) handled by the multi-cycle core
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Control FSM states; codes 12-15 are unused
    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StRwb    = 4'd7,
        StBranch = 4'd8,
        StJump   = 4'd9,
        StImmEx  = 4'd10,
        StImmWb  = 4'd11
    } stateE;

    // ALU operation select
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    // ALU B operand select
    localparam logic [1:0] SRC_B_RT     = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic [1:0] SRC_B_IMMSH  = 2'b11;

    // PC source select
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // Immediate needs sign extension (addiu is deliberately zero-extended here)
    function automatic logic isSignExt(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing the shared memory/ALU
// datapath, with a memory-ready handshake in FETCH, MEMRD and MEMWR.
// Optional performance counters are enabled by defining MULTICYCLE_CONTROL_PERF_EN.
module multicycle_control
    import mips_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [5:0]       i_instrCode,
    input  logic             i_memReady,
    output logic             o_pcWrite,
    output logic             o_pcWriteCond,
    output logic             o_iorD,
    output logic             o_memRead,
    output logic             o_memWrite,
    output logic             o_irWrite,
    output logic             o_regDst,
    output logic             o_memToReg,
    output logic             o_regWrite,
    output logic             o_aluSrcA,
    output logic [1:0]       o_aluSrcB,
    output logic [1:0]       o_aluOp,
    output logic [1:0]       o_pcSource,
    output logic             o_extOp,
    output logic             o_illegal,
    output logic [3:0]       o_state
`ifdef MULTICYCLE_CONTROL_PERF_EN
    ,
    output logic [CNT_W-1:0] o_cycleCount,
    output logic [CNT_W-1:0] o_instrCount
`endif
);

    if (CNT_W == 0) begin : gCntWCheck
        $error("CNT_W must be at least 1");
    end

    stateE stateQ, stateD;

    // State register; reset aborts any instruction in flight
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stateQ <= StFetch;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state and Moore output decode
    always_comb begin
        stateD        = stateQ;
        o_pcWrite     = 1'b0;
        o_pcWriteCond = 1'b0;
        o_iorD        = 1'b0;
        o_memRead     = 1'b0;
        o_memWrite    = 1'b0;
        o_irWrite     = 1'b0;
        o_regDst      = 1'b0;
        o_memToReg    = 1'b0;
        o_regWrite    = 1'b0;
        o_aluSrcA     = 1'b0;
        o_aluSrcB     = SRC_B_RT;
        o_aluOp       = ALU_OP_ADD;
        o_pcSource    = PC_SRC_ALU;
        o_extOp       = isSignExt(i_instrCode);
        o_illegal     = 1'b0;

        case (stateQ)
            StFetch: begin
                // Opcode is not yet valid in FETCH, so no extension hint
                o_extOp   = 1'b0;
                o_memRead = 1'b1;
                o_aluSrcB = SRC_B_FOUR;
                // Reset holds state at FETCH; keep IR/PC from loading meanwhile
                o_irWrite = i_memReady & ~i_rst;
                o_pcWrite = i_memReady & ~i_rst;
                if (i_memReady) begin
                    stateD = StDecode;
                end
            end
            StDecode: begin
                o_aluSrcB = SRC_B_IMMSH;
                case (i_instrCode)
                    OP_LW, OP_SW:      stateD = StMemAdr;
                    OP_RTYPE:          stateD = StExec;
                    OP_ADDI, OP_ADDIU: stateD = StImmEx;
                    OP_BEQ:            stateD = StBranch;
                    OP_J:              stateD = StJump;
                    default: begin
                        o_illegal = 1'b1;
                        stateD    = StFetch;
                    end
                endcase
            end
            StMemAdr: begin
                o_aluSrcA = 1'b1;
                o_aluSrcB = SRC_B_IMM;
                stateD    = (i_instrCode == OP_SW) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                o_memRead = 1'b1;
                o_iorD    = 1'b1;
                if (i_memReady) begin
                    stateD = StMemWb;
                end
            end
            StMemWb: begin
                o_regWrite = 1'b1;
                o_memToReg = 1'b1;
                stateD     = StFetch;
            end
            StMemWr: begin
                o_memWrite = 1'b1;
                o_iorD     = 1'b1;
                if (i_memReady) begin
                    stateD = StFetch;
                end
            end
            StExec: begin
                o_aluSrcA = 1'b1;
                o_aluOp   = ALU_OP_FUNCT;
                stateD    = StRwb;
            end
            StRwb: begin
                o_regWrite = 1'b1;
                o_regDst   = 1'b1;
                stateD     = StFetch;
            end
            StBranch: begin
                o_aluSrcA     = 1'b1;
                o_aluOp       = ALU_OP_SUB;
                o_pcWriteCond = 1'b1;
                o_pcSource    = PC_SRC_ALUOUT;
                stateD        = StFetch;
            end
            StJump: begin
                o_pcWrite  = 1'b1;
                o_pcSource = PC_SRC_JUMP;
                stateD     = StFetch;
            end
            StImmEx: begin
                o_aluSrcA = 1'b1;
                o_aluSrcB = SRC_B_IMM;
                stateD    = StImmWb;
            end
            StImmWb: begin
                o_regWrite = 1'b1;
                stateD     = StFetch;
            end
            default: begin
                // Unused codes: recover to FETCH with everything quiet
                o_extOp = 1'b0;
                stateD  = StFetch;
            end
        endcase
    end

    assign o_state = stateQ;

`ifdef MULTICYCLE_CONTROL_PERF_EN
    logic [CNT_W-1:0] cycleCountQ, instrCountQ;

    // Saturating cycle and retired-instruction counters
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cycleCountQ <= '0;
            instrCountQ <= '0;
        end else begin
            if (cycleCountQ != '1) begin
                cycleCountQ <= cycleCountQ + 1'b1;
            end
            if ((stateQ != StFetch) && (stateD == StFetch) && (instrCountQ != '1)) begin
                instrCountQ <= instrCountQ + 1'b1;
            end
        end
    end

    assign o_cycleCount = cycleCountQ;
    assign o_instrCount = instrCountQ;
`endif

endmodule
